// File: rtl/pc_stall_ctrl.sv
// Next-PC and pipeline-hazard controller: picks pc+4, a branch redirect or a hold,
// and drives the matching IF/ID and ID/EX hold, flush and bubble strobes.
module pc_stall_ctrl #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          SAT_W    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            ex_memread,
  input  logic [4:0]      ex_rt,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            mc_start,
  input  logic [3:0]      mc_cycles,
  output logic            PCWrite,
  output logic [XLEN-1:0] nextpc,
  output logic            ifid_hold,
  output logic            ifid_flush,
  output logic            idex_hold,
  output logic            idex_bubble,
  output logic            exmem_bubble,
  output logic [SAT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MCBUSY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       mc_cnt_q, mc_cnt_d;
  logic [SAT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic            load_use_hit;
  logic [XLEN-1:0] pc_plus4;

  assign load_use_hit = ex_memread && (ex_rt != 5'd0) &&
                        ((id_uses_rs && (id_rs == ex_rt)) ||
                         (id_uses_rt && (id_rt == ex_rt)));
  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    state_d      = state_q;
    mc_cnt_d     = mc_cnt_q;
    PCWrite      = 1'b0;
    nextpc       = pc_plus4;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_hold    = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;

    if (!rst_n) begin
      PCWrite = 1'b1;
      nextpc  = XLEN'(RESET_PC);
    end else begin
      case (state_q)
        MCBUSY: begin
          PCWrite      = 1'b1;
          ifid_hold    = 1'b1;
          idex_hold    = 1'b1;
          exmem_bubble = 1'b1;
          // The entry cycle already stalled once, so the last busy cycle is the one at count 1.
          if (mc_cnt_q <= 4'd1) begin
            mc_cnt_d = 4'd0;
            state_d  = RUN;
          end else begin
            mc_cnt_d = mc_cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = RUN;
          if (br_taken) begin
            nextpc      = br_target;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (mc_start && (mc_cycles >= 4'd2)) begin
            PCWrite      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            mc_cnt_d     = mc_cycles - 4'd2;
            if (mc_cycles >= 4'd3) begin
              state_d = MCBUSY;
            end
          end else if (load_use_hit && (state_q == RUN)) begin
            // In LSTALL the bubble sits in EX, so the stale load must not re-trigger.
            PCWrite     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            state_d     = LSTALL;
          end
        end
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (PCWrite && (stall_cycles_q != {SAT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + SAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      mc_cnt_q       <= 4'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mc_cnt_q       <= mc_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pc_stall_ctrl.sv
// Directed bench for pc_stall_ctrl: hand-computed expectations per cycle,
// plus a second instance with a 4-bit statistics counter to exercise saturation.
module tb_pc_stall_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, ex_memread, br_taken, mc_start;
  logic [31:0] br_target;
  logic [3:0]  mc_cycles;

  logic        pcw, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_bubble;
  logic [31:0] nextpc;
  logic [15:0] stall_cycles;

  logic        s_pcw, s_ifid_hold, s_ifid_flush, s_idex_hold, s_idex_bubble, s_exmem_bubble;
  logic [31:0] s_nextpc;
  logic [3:0]  s_stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  pc_stall_ctrl #(.XLEN(32), .RESET_PC(32'd0), .SAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .br_taken(br_taken), .br_target(br_target),
    .mc_start(mc_start), .mc_cycles(mc_cycles),
    .PCWrite(pcw), .nextpc(nextpc), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_hold(idex_hold), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .stall_cycles(stall_cycles)
  );

  pc_stall_ctrl #(.XLEN(32), .RESET_PC(32'd0), .SAT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .br_taken(br_taken), .br_target(br_target),
    .mc_start(mc_start), .mc_cycles(mc_cycles),
    .PCWrite(s_pcw), .nextpc(s_nextpc), .ifid_hold(s_ifid_hold), .ifid_flush(s_ifid_flush),
    .idex_hold(s_idex_hold), .idex_bubble(s_idex_bubble), .exmem_bubble(s_exmem_bubble),
    .stall_cycles(s_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_rt = 5'd0; br_taken = 1'b0; br_target = 32'd0;
    mc_start = 1'b0; mc_cycles = 4'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Compare the full strobe vector {PCWrite, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_bubble}.
  task automatic check_strobes(input string tag, input logic [5:0] exp);
    check_eq(tag, 32'({pcw, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_bubble}), 32'(exp));
  endtask

  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_LOAD  = 6'b110010;
  localparam logic [5:0] S_BR    = 6'b001010;
  localparam logic [5:0] S_MC    = 6'b110101;
  localparam logic [5:0] S_RESET = 6'b100000;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    pc    = 32'h40;
    #2;
    check_strobes("reset_strobes", S_RESET);
    check_eq("reset_nextpc", nextpc, 32'h0);
    check_eq("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    next_cycle();
    next_cycle();
    check_eq("reset_hold_nextpc", nextpc, 32'h0);
    rst_n = 1'b1;
    #1;

    // Idle advance with the bench acting as the PC register
    check_strobes("idle0_strobes", S_NONE);
    check_eq("idle0_nextpc", nextpc, 32'h44);
    next_cycle(); pc = 32'h44; #1;
    check_eq("idle1_nextpc", nextpc, 32'h48);
    next_cycle(); pc = 32'h48; #1;
    check_eq("idle2_nextpc", nextpc, 32'h4C);
    check_eq("idle_stall_cnt", 32'(stall_cycles), 32'd0);

    // Load-use on rs
    next_cycle(); pc = 32'h4C;
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1; #1;
    check_strobes("lu_rs_stall", S_LOAD);
    next_cycle(); #1;
    check_strobes("lu_rs_masked", S_NONE);
    check_eq("lu_rs_masked_nextpc", nextpc, 32'h50);
    check_eq("lu_stall_cnt1", 32'(stall_cycles), 32'd1);

    // $zero destination and unused source do not stall
    next_cycle(); idle_inputs(); pc = 32'h50;
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1; #1;
    check_strobes("lu_zero_reg", S_NONE);
    idle_inputs(); ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b0; #1;
    check_strobes("lu_unused_rt", S_NONE);
    id_uses_rt = 1'b1; #1;
    check_strobes("lu_rt_stall", S_LOAD);
    next_cycle(); #1;
    check_strobes("lu_rt_masked", S_NONE);
    check_eq("lu_stall_cnt2", 32'(stall_cycles), 32'd2);

    // Branch beats load-use and does not enter LSTALL
    next_cycle(); pc = 32'h54;
    ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1; id_uses_rt = 1'b0;
    br_taken = 1'b1; br_target = 32'h100; #1;
    check_strobes("br_strobes", S_BR);
    check_eq("br_nextpc", nextpc, 32'h100);
    next_cycle(); br_taken = 1'b0; pc = 32'h100; #1;
    check_strobes("br_then_lu_still_run", S_LOAD);
    next_cycle(); idle_inputs(); #1;
    check_strobes("br_lu_done", S_NONE);
    check_eq("br_stall_cnt", 32'(stall_cycles), 32'd3);

    // Multi-cycle op of 5: four stall cycles, branch/mc pulses inside ignored
    next_cycle(); pc = 32'h200; mc_start = 1'b1; mc_cycles = 4'd5; #1;
    check_strobes("mc5_c0", S_MC);
    check_eq("mc5_c0_nextpc", nextpc, 32'h204);
    next_cycle(); idle_inputs(); #1;
    check_strobes("mc5_c1", S_MC);
    next_cycle(); br_taken = 1'b1; br_target = 32'h300; #1;
    check_strobes("mc5_c2_br_ignored", S_MC);
    check_eq("mc5_c2_nextpc", nextpc, 32'h204);
    next_cycle(); br_taken = 1'b0; mc_start = 1'b1; mc_cycles = 4'd5; #1;
    check_strobes("mc5_c3_mc_ignored", S_MC);
    next_cycle(); idle_inputs(); #1;
    check_strobes("mc5_done", S_NONE);
    check_eq("mc5_stall_cnt", 32'(stall_cycles), 32'd7);
    check_eq("sat_below_limit", 32'(s_stall_cycles), 32'd7);

    // mc_cycles=2 is a single stall in RUN; mc_cycles=1 no stall
    next_cycle(); mc_start = 1'b1; mc_cycles = 4'd2; #1;
    check_strobes("mc2_c0", S_MC);
    next_cycle(); mc_start = 1'b1; mc_cycles = 4'd1; #1;
    check_strobes("mc1_no_stall", S_NONE);
    next_cycle(); idle_inputs(); #1;
    check_eq("mc2_stall_cnt", 32'(stall_cycles), 32'd8);

    // PC wrap
    pc = 32'hFFFF_FFFC; #1;
    check_eq("wrap_nextpc", nextpc, 32'h0);

    // Long stall: 14 cycles pushes the 4-bit counter into saturation
    next_cycle(); pc = 32'h400; mc_start = 1'b1; mc_cycles = 4'd15; #1;
    next_cycle(); idle_inputs();
    repeat (13) next_cycle();
    #1;
    check_strobes("mc15_done", S_NONE);
    check_eq("long_stall_cnt", 32'(stall_cycles), 32'd22);
    check_eq("sat_held", 32'(s_stall_cycles), 32'd15);

    // Reset in the middle of a multi-cycle stall
    next_cycle(); mc_start = 1'b1; mc_cycles = 4'd5; #1;
    next_cycle(); idle_inputs(); #1;
    check_strobes("mid_mc_stalled", S_MC);
    #2; rst_n = 1'b0; #1;
    check_strobes("async_reset_strobes", S_RESET);
    check_eq("async_reset_nextpc", nextpc, 32'h0);
    check_eq("async_reset_cnt", 32'(stall_cycles), 32'd0);
    next_cycle(); rst_n = 1'b1; pc = 32'h400; #1;
    check_strobes("post_reset_run", S_NONE);
    check_eq("post_reset_nextpc", nextpc, 32'h404);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
